// File: rtl/apb_root_decoder_if.sv
// Bus bundle for the APB root decoder: the upstream requester stream from the
// QSPI bridge plus the shared/per-port downstream completer fabric.
interface apb_root_decoder_if #(
  parameter int NUM_PORTS  = 8,
  parameter int BLOCK_BITS = 16,
  parameter int DATA_WIDTH = 32
);
  // Upstream requester side
  logic                       s_psel;
  logic                       s_penable;
  logic                       s_pwrite;
  logic [23:0]                s_paddr;
  logic [DATA_WIDTH-1:0]      s_pwdata;
  logic [DATA_WIDTH/8-1:0]    s_pstrb;
  logic                       s_pready;
  logic [DATA_WIDTH-1:0]      s_prdata;
  logic                       s_pslverr;

  // Downstream completer side
  logic [NUM_PORTS-1:0]            m_psel;
  logic                            m_penable;
  logic                            m_pwrite;
  logic [BLOCK_BITS-1:0]           m_paddr;
  logic [DATA_WIDTH-1:0]           m_pwdata;
  logic [DATA_WIDTH/8-1:0]         m_pstrb;
  logic [NUM_PORTS-1:0]            m_pready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] m_prdata;
  logic [NUM_PORTS-1:0]            m_pslverr;

  // Decoder view: completer to the bridge, requester to the peripherals
  modport slave (
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
    output s_pready, s_prdata, s_pslverr,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb,
    input  m_pready, m_prdata, m_pslverr
  );

  // Environment view: the bridge upstream and the peripherals downstream
  modport master (
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
    input  s_pready, s_prdata, s_pslverr,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb,
    output m_pready, m_prdata, m_pslverr
  );
endinterface

// File: rtl/apb_root_decoder.sv
// APB root decoder: re-times the bridge's requester stream into proper
// SETUP/ACCESS phases, routes each transfer to one peripheral window, and
// guards every ACCESS phase with a watchdog so a dead completer answers with
// PSLVERR instead of stalling the management link.
module apb_root_decoder #(
  parameter int NUM_PORTS      = 8,
  parameter int BLOCK_BITS     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  apb_root_decoder_if.slave  bus,
  output logic [15:0]        timeout_count,
  output logic [23:0]        last_err_addr
);

  // A single-port build still keeps a 1-bit select field; a set bit there is
  // simply an out-of-range window.
  localparam int SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int HI_LSB = BLOCK_BITS + SEL_W;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [SEL_W-1:0]        sel_q;
  logic [23:0]             addr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_W-1:0]       pstrb_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_PORTS-1:0]    m_psel_q;
  logic                    m_penable_q;
  logic                    s_pready_q;
  logic [DATA_WIDTH-1:0]   s_prdata_q;
  logic                    s_pslverr_q;
  logic [15:0]             timeout_count_q;
  logic [23:0]             last_err_addr_q;

  logic [SEL_W-1:0]        sel_d;
  logic                    dec_err_d;
  logic                    rdy_sel;
  logic                    err_sel;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  logic                    last_cycle;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NUM_PORTS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (s == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Address decode of the live upstream request: window index plus the
  // out-of-range / stray-high-bit error check.
  always_comb begin
    sel_d     = bus.s_paddr[BLOCK_BITS +: SEL_W];
    dec_err_d = (32'(sel_d) >= 32'(NUM_PORTS)) ||
                ((bus.s_paddr >> HI_LSB) != 24'd0);
  end

  // Pick the selected completer's ready/error/data using the captured select.
  always_comb begin
    rdy_sel   = 1'b0;
    err_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        rdy_sel   = bus.m_pready[i];
        err_sel   = bus.m_pslverr[i];
        rdata_sel = bus.m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    last_cycle = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Transfer sequencer with registered bus outputs and error bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      addr_q          <= '0;
      pwrite_q        <= 1'b0;
      pwdata_q        <= '0;
      pstrb_q         <= '0;
      cnt_q           <= '0;
      m_psel_q        <= '0;
      m_penable_q     <= 1'b0;
      s_pready_q      <= 1'b0;
      s_prdata_q      <= '0;
      s_pslverr_q     <= 1'b0;
      timeout_count_q <= '0;
      last_err_addr_q <= '0;
    end else begin
      s_pready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.s_psel && bus.s_penable) begin
            addr_q   <= bus.s_paddr;
            pwrite_q <= bus.s_pwrite;
            pwdata_q <= bus.s_pwdata;
            pstrb_q  <= bus.s_pstrb;
            sel_q    <= sel_d;
            if (dec_err_d) begin
              // Nothing lives at this address: answer straight away.
              state_q         <= RESP;
              s_pready_q      <= 1'b1;
              s_prdata_q      <= '0;
              s_pslverr_q     <= 1'b1;
              last_err_addr_q <= bus.s_paddr;
            end else begin
              state_q  <= SETUP;
              m_psel_q <= onehot(sel_d);
            end
          end
        end

        SETUP: begin
          state_q     <= ACCESS;
          m_penable_q <= 1'b1;
          cnt_q       <= '0;
        end

        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (rdy_sel) begin
            // Completer answered (takes priority even on the last allowed cycle).
            state_q     <= RESP;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            s_pready_q  <= 1'b1;
            s_prdata_q  <= pwrite_q ? '0 : rdata_sel;
            s_pslverr_q <= err_sel;
            if (err_sel) last_err_addr_q <= addr_q;
          end else if (last_cycle) begin
            // Watchdog expiry: abandon the completer and report an error.
            state_q         <= RESP;
            m_psel_q        <= '0;
            m_penable_q     <= 1'b0;
            s_pready_q      <= 1'b1;
            s_prdata_q      <= '0;
            s_pslverr_q     <= 1'b1;
            last_err_addr_q <= addr_q;
            if (timeout_count_q != 16'hFFFF) timeout_count_q <= timeout_count_q + 16'd1;
          end
        end

        RESP: begin
          // Upstream is still holding psel/penable here; do not recapture.
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_psel      = m_psel_q;
  assign bus.m_penable   = m_penable_q;
  assign bus.m_pwrite    = pwrite_q;
  assign bus.m_paddr     = addr_q[BLOCK_BITS-1:0];
  assign bus.m_pwdata    = pwdata_q;
  assign bus.m_pstrb     = pstrb_q;
  assign bus.s_pready    = s_pready_q;
  assign bus.s_prdata    = s_prdata_q;
  assign bus.s_pslverr   = s_pslverr_q;
  assign timeout_count   = timeout_count_q;
  assign last_err_addr   = last_err_addr_q;

endmodule

// File: tb/tb_apb_root_decoder.sv
// Self-checking bench for apb_root_decoder: directed transfers against a
// transaction-level schedule model plus hand-computed spot values.
module tb_apb_root_decoder;

  localparam int NP   = 8;
  localparam int BB   = 16;
  localparam int DW   = 32;
  localparam int TO   = 4;
  localparam int SW   = DW / 8;
  localparam int MAXC = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] timeout_count;
  logic [23:0] last_err_addr;

  apb_root_decoder_if #(.NUM_PORTS(NP), .BLOCK_BITS(BB), .DATA_WIDTH(DW)) bus ();

  apb_root_decoder #(
    .NUM_PORTS(NP), .BLOCK_BITS(BB), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .timeout_count(timeout_count),
    .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completer models: port i answers after waits_cfg[i] ACCESS wait cycles.
  int          waits_cfg [NP];
  logic [DW-1:0] rdata_cfg [NP];
  logic        perr_cfg  [NP];
  int          acc_cnt = 0;

  always @(posedge clk) acc_cnt <= (bus.m_penable && (|bus.m_psel)) ? acc_cnt + 1 : 0;

  always_comb begin
    logic r;
    bus.m_pready  = '0;
    bus.m_pslverr = '0;
    bus.m_prdata  = '0;
    for (int i = 0; i < NP; i++) begin
      r = bus.m_psel[i] && bus.m_penable && (acc_cnt == waits_cfg[i]);
      bus.m_pready[i]  = r;
      bus.m_pslverr[i] = r && perr_cfg[i];
      bus.m_prdata[i*DW +: DW] = rdata_cfg[i];
    end
  end

  // Expected per-cycle schedule, filled in when a request is issued.
  logic [NP-1:0] e_psel [MAXC];
  bit            e_pen  [MAXC];
  bit            e_rdy  [MAXC];
  bit            e_err  [MAXC];
  bit            e_to   [MAXC];
  logic [DW-1:0] e_rd   [MAXC];
  logic [23:0]   e_ad   [MAXC];

  logic [23:0]   cur_addr;
  logic          cur_wr;
  logic [DW-1:0] cur_wd;
  logic [SW-1:0] cur_st;

  logic [DW-1:0] m_hold = '0;
  logic [15:0]   m_tc   = '0;
  logic [23:0]   m_lea  = '0;

  logic [NP-1:0] last_psel  = '0;
  logic [BB-1:0] last_paddr = '0;

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_psel[i] = '0; e_pen[i] = 1'b0; e_rdy[i] = 1'b0;
      e_err[i] = 1'b0; e_to[i] = 1'b0; e_rd[i] = '0; e_ad[i] = '0;
    end
  endtask

  // Compare process: every cycle, DUT outputs against the schedule model.
  always @(negedge clk) begin : compare
    int c;
    c = cyc;
    if (c < MAXC) begin
      if (e_rdy[c]) begin
        m_hold = e_rd[c];
        if (e_err[c]) m_lea = e_ad[c];
        if (e_to[c] && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
      end
      chk("m_psel",        64'(bus.m_psel),    64'(e_psel[c]));
      chk("m_penable",     64'(bus.m_penable), 64'(e_pen[c]));
      chk("s_pready",      64'(bus.s_pready),  64'(e_rdy[c]));
      chk("s_prdata",      64'(bus.s_prdata),  64'(m_hold));
      chk("timeout_count", 64'(timeout_count), 64'(m_tc));
      chk("last_err_addr", 64'(last_err_addr), 64'(m_lea));
      if (e_rdy[c]) chk("s_pslverr", 64'(bus.s_pslverr), 64'(e_err[c]));
      if (e_psel[c] != '0) begin
        chk("m_paddr",  64'(bus.m_paddr),  64'(cur_addr[BB-1:0]));
        chk("m_pwrite", 64'(bus.m_pwrite), 64'(cur_wr));
        chk("m_pwdata", 64'(bus.m_pwdata), 64'(cur_wd));
        chk("m_pstrb",  64'(bus.m_pstrb),  64'(cur_st));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.m_penable) begin
      last_psel  = bus.m_psel;
      last_paddr = bus.m_paddr;
    end
  end

  // Drive one request and record its expected timeline; n is the capture cycle.
  task automatic issue_req(input logic [23:0] a, input logic wr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] st, output int n);
    int port, w, acc, r;
    bit timed;
    @(posedge clk); #1;
    n = cyc;
    cur_addr = a; cur_wr = wr; cur_wd = wd; cur_st = st;
    bus.s_paddr = a; bus.s_pwrite = wr; bus.s_pwdata = wd; bus.s_pstrb = st;
    bus.s_psel = 1'b1; bus.s_penable = 1'b1;
    port = int'(a >> BB);
    if (port >= NP) begin
      r = n + 1;
      e_rdy[r] = 1'b1; e_rd[r] = '0; e_err[r] = 1'b1; e_to[r] = 1'b0; e_ad[r] = a;
    end else begin
      w     = waits_cfg[port];
      timed = (w + 1 > TO);
      acc   = timed ? TO : w + 1;
      e_psel[n+1] = NP'(1) << port;
      e_pen[n+1]  = 1'b0;
      for (int k = 0; k < acc; k++) begin
        e_psel[n+2+k] = NP'(1) << port;
        e_pen[n+2+k]  = 1'b1;
      end
      r = n + 2 + acc;
      e_rdy[r] = 1'b1;
      e_rd[r]  = (timed || wr) ? '0 : rdata_cfg[port];
      e_err[r] = timed ? 1'b1 : perr_cfg[port];
      e_to[r]  = timed;
      e_ad[r]  = a;
    end
  endtask

  // Hold the request until s_pready, then drop it; bounded wait.
  task automatic wait_resp(output int r, output logic [DW-1:0] rd, output logic er);
    bit got;
    got = 1'b0; r = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.s_pready) begin
        got = 1'b1; r = cyc; rd = bus.s_prdata; er = bus.s_pslverr;
      end
    end
    bus.s_psel = 1'b0; bus.s_penable = 1'b0;
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL resp_wait: no s_pready within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin : stim
    int n, r;
    logic [DW-1:0] rd;
    logic er;

    for (int i = 0; i < NP; i++) begin
      waits_cfg[i] = 0; rdata_cfg[i] = 32'hD000_0000 | DW'(i); perr_cfg[i] = 1'b0;
    end
    waits_cfg[0] = 255; rdata_cfg[0] = 32'h0BAD_F00D;
    waits_cfg[1] = 255;
    waits_cfg[3] = 3;   rdata_cfg[3] = 32'h3333_3333;
    waits_cfg[5] = 3;   rdata_cfg[5] = 32'h1234_5678;
    waits_cfg[6] = 1;   perr_cfg[6]  = 1'b1;
    waits_cfg[7] = 2;   rdata_cfg[7] = 32'h7766_5544;
    bus.s_psel = 1'b0; bus.s_penable = 1'b0; bus.s_pwrite = 1'b0;
    bus.s_paddr = '0; bus.s_pwdata = '0; bus.s_pstrb = '0;
    cur_addr = '0; cur_wr = 1'b0; cur_wd = '0; cur_st = '0;
    clear_from(0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_psel",    64'(bus.m_psel),    64'h0);
    chk("rst_m_penable", 64'(bus.m_penable), 64'h0);
    chk("rst_s_pready",  64'(bus.s_pready),  64'h0);
    chk("rst_s_pslverr", 64'(bus.s_pslverr), 64'h0);
    chk("rst_timeouts",  64'(timeout_count), 64'h0);
    rst = 1'b0;

    // Zero-wait write to port 2
    issue_req(24'h020004, 1'b1, 32'hCAFE_BABE, 4'hF, n);
    wait_resp(r, rd, er);
    chk("wr_latency",   64'(r - n),      64'd3);
    chk("wr_pslverr",   64'(er),         64'h0);
    chk("wr_prdata",    64'(rd),         64'h0);
    chk("wr_psel",      64'(last_psel),  64'h04);
    chk("wr_paddr",     64'(last_paddr), 64'h0004);

    // Read from port 5 with 3 wait states
    issue_req(24'h050010, 1'b0, 32'h0, 4'h0, n);
    wait_resp(r, rd, er);
    chk("rd5_latency",  64'(r - n), 64'd6);
    chk("rd5_prdata",   64'(rd),    64'h1234_5678);
    chk("rd5_pslverr",  64'(er),    64'h0);

    // Out-of-range window
    issue_req(24'h090000, 1'b0, 32'h0, 4'h0, n);
    wait_resp(r, rd, er);
    chk("dec_latency",  64'(r - n),      64'd1);
    chk("dec_pslverr",  64'(er),         64'h1);
    chk("dec_prdata",   64'(rd),         64'h0);
    chk("dec_err_addr", 64'(last_err_addr), 64'h09_0000);

    // Port 1 never answers: watchdog
    issue_req(24'h010000, 1'b0, 32'h0, 4'h0, n);
    wait_resp(r, rd, er);
    chk("to_latency",   64'(r - n),         64'd6);
    chk("to_pslverr",   64'(er),            64'h1);
    chk("to_prdata",    64'(rd),            64'h0);
    chk("to_count",     64'(timeout_count), 64'd1);

    // Port 3 answers on the final allowed ACCESS cycle
    issue_req(24'h030008, 1'b0, 32'h0, 4'h0, n);
    wait_resp(r, rd, er);
    chk("edge_latency", 64'(r - n),         64'd6);
    chk("edge_pslverr", 64'(er),            64'h0);
    chk("edge_prdata",  64'(rd),            64'h3333_3333);
    chk("edge_count",   64'(timeout_count), 64'd1);

    // Completer-signalled PSLVERR on a partial-strobe write
    issue_req(24'h060020, 1'b1, 32'h0000_5A5A, 4'h3, n);
    wait_resp(r, rd, er);
    chk("perr_latency", 64'(r - n),         64'd4);
    chk("perr_pslverr", 64'(er),            64'h1);
    chk("perr_addr",    64'(last_err_addr), 64'h06_0020);

    // Top of port 7's window, 2 wait states
    issue_req(24'h07FFFC, 1'b0, 32'h0, 4'h0, n);
    wait_resp(r, rd, er);
    chk("rd7_latency",  64'(r - n),      64'd5);
    chk("rd7_prdata",   64'(rd),         64'h7766_5544);
    chk("rd7_paddr",    64'(last_paddr), 64'hFFFC);

    // Reset in the middle of an ACCESS phase to port 0
    issue_req(24'h000040, 1'b0, 32'h0, 4'h0, n);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_penable", 64'(bus.m_penable), 64'h1);
    rst = 1'b1;
    clear_from(cyc);
    m_hold = '0; m_tc = '0; m_lea = '0;
    bus.s_psel = 1'b0; bus.s_penable = 1'b0;
    #1;
    chk("abort_m_psel",    64'(bus.m_psel),    64'h0);
    chk("abort_m_penable", 64'(bus.m_penable), 64'h0);
    chk("abort_s_pready",  64'(bus.s_pready),  64'h0);
    chk("abort_timeouts",  64'(timeout_count), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    waits_cfg[0] = 0;

    issue_req(24'h000044, 1'b0, 32'h0, 4'h0, n);
    wait_resp(r, rd, er);
    chk("post_rst_latency", 64'(r - n), 64'd3);
    chk("post_rst_prdata",  64'(rd),    64'h0BAD_F00D);
    chk("post_rst_pslverr", 64'(er),    64'h0);

    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
